// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with saturating direction counters and a flush sweep FSM.
// Optional statistics counters are built when the macro BTB_STATS_EN is defined.
module btb_assoc #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned WAYS       = 2,
  parameter int unsigned CTR_BITS   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rd_pc,
  output logic        rd_hit,
  output logic        rd_taken,
  output logic [31:0] rd_target,
  input  logic        wr_req,
  input  logic [31:0] wr_pc,
  input  logic [31:0] wr_target,
  input  logic        wr_taken,
  input  logic        flush,
  output logic        busy
`ifdef BTB_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] mispredict_cnt
`endif
);

  localparam int unsigned SETS  = 1 << INDEX_BITS;
  localparam int unsigned TAG_W = 30 - INDEX_BITS;
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1 << (CTR_BITS - 1));

  typedef enum logic [0:0] {StIdle, StSweep} state_e;

  state_e                state_q, state_d;
  logic [INDEX_BITS-1:0] sweep_idx_q, sweep_idx_d;

  logic                valid_q  [SETS][WAYS];
  logic [TAG_W-1:0]    tag_q    [SETS][WAYS];
  logic [31:0]         target_q [SETS][WAYS];
  logic [CTR_BITS-1:0] ctr_q    [SETS][WAYS];
  logic [WAY_W-1:0]    rr_q     [SETS];

  logic [TAG_W-1:0]      rd_tag, wr_tag;
  logic [INDEX_BITS-1:0] rd_idx, wr_idx;
  logic                  unused_pc;

  assign rd_tag    = rd_pc[31:INDEX_BITS+2];
  assign rd_idx    = rd_pc[INDEX_BITS+1:2];
  assign wr_tag    = wr_pc[31:INDEX_BITS+2];
  assign wr_idx    = wr_pc[INDEX_BITS+1:2];
  assign unused_pc = ^{rd_pc[1:0], wr_pc[1:0]};

  // Lookup port
  logic             rd_match;
  logic [WAY_W-1:0] rd_way;

  always_comb begin
    rd_match = 1'b0;
    rd_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!rd_match && valid_q[rd_idx][w] && (tag_q[rd_idx][w] == rd_tag)) begin
        rd_match = 1'b1;
        rd_way   = WAY_W'(w);
      end
    end
  end

  assign rd_hit    = rd_match & ~busy;
  assign rd_taken  = rd_hit & ctr_q[rd_idx][rd_way][CTR_BITS-1];
  assign rd_target = rd_hit ? target_q[rd_idx][rd_way] : '0;

  // Update port: hit detection and victim selection
  logic             wr_hit;
  logic [WAY_W-1:0] wr_way;
  logic             inv_found;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] victim_way;
  logic [WAY_W-1:0] rr_next;

  always_comb begin
    wr_hit    = 1'b0;
    wr_way    = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!wr_hit && valid_q[wr_idx][w] && (tag_q[wr_idx][w] == wr_tag)) begin
        wr_hit = 1'b1;
        wr_way = WAY_W'(w);
      end
      if (!inv_found && !valid_q[wr_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  assign victim_way = inv_found ? inv_way : rr_q[wr_idx];
  assign rr_next    = (WAYS > 1) ? rr_q[wr_idx] + WAY_W'(1) : '0;

  logic                accept;
  logic                do_upd;
  logic                do_alloc;
  logic [CTR_BITS-1:0] ctr_cur;
  logic [CTR_BITS-1:0] ctr_upd;

  // Flush wins over a same-cycle update; nothing is written while sweeping.
  assign accept   = wr_req & (state_q == StIdle) & ~flush;
  assign do_upd   = accept & wr_hit;
  assign do_alloc = accept & ~wr_hit & wr_taken;
  assign ctr_cur  = ctr_q[wr_idx][wr_way];

  always_comb begin
    ctr_upd = ctr_cur;
    if (wr_taken) begin
      if (ctr_cur != '1) ctr_upd = ctr_cur + CTR_BITS'(1);
    end else begin
      if (ctr_cur != '0) ctr_upd = ctr_cur - CTR_BITS'(1);
    end
  end

  // Reset-cleared state: valid, counters, round-robin pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        rr_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          ctr_q[s][w]   <= '0;
        end
      end
    end else if (state_q == StSweep) begin
      rr_q[sweep_idx_q] <= '0;
      for (int w = 0; w < WAYS; w++) valid_q[sweep_idx_q][w] <= 1'b0;
    end else if (do_upd) begin
      ctr_q[wr_idx][wr_way] <= ctr_upd;
    end else if (do_alloc) begin
      valid_q[wr_idx][victim_way] <= 1'b1;
      ctr_q[wr_idx][victim_way]   <= CTR_WEAK;
      if (!inv_found) rr_q[wr_idx] <= rr_next;
    end
  end

  // Tag and target storage carry no reset
  always_ff @(posedge clk) begin
    if (do_upd && wr_taken) begin
      target_q[wr_idx][wr_way] <= wr_target;
    end else if (do_alloc) begin
      tag_q[wr_idx][victim_way]    <= wr_tag;
      target_q[wr_idx][victim_way] <= wr_target;
    end
  end

  // Flush FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      sweep_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    unique case (state_q)
      StIdle: begin
        if (flush) begin
          state_d     = StSweep;
          sweep_idx_d = '0;
        end
      end
      StSweep: begin
        if (sweep_idx_q == '1) state_d = StIdle;
        else sweep_idx_d = sweep_idx_q + INDEX_BITS'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StSweep);
  end

`ifdef BTB_STATS_EN
  logic pred_taken;
  logic mispredict;

  assign pred_taken = wr_hit & ctr_cur[CTR_BITS-1];
  assign mispredict = (pred_taken != wr_taken) |
                      (pred_taken & wr_taken & (target_q[wr_idx][wr_way] != wr_target));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt        <= '0;
      mispredict_cnt <= '0;
    end else if (accept) begin
      if (wr_hit) hit_cnt <= hit_cnt + 32'd1;
      if (mispredict) mispredict_cnt <= mispredict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_btb_assoc.sv
// Scoreboard bench for btb_assoc: stimulus queues expected lookups, a negedge monitor compares.
module tb_btb_assoc;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rd_pc;
  logic        rd_hit;
  logic        rd_taken;
  logic [31:0] rd_target;
  logic        wr_req;
  logic [31:0] wr_pc;
  logic [31:0] wr_target;
  logic        wr_taken;
  logic        flush;
  logic        busy;
`ifdef BTB_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] mispredict_cnt;
`endif

  always #5 clk = ~clk;

  btb_assoc #(
    .INDEX_BITS(6),
    .WAYS      (2),
    .CTR_BITS  (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_pc    (rd_pc),
    .rd_hit   (rd_hit),
    .rd_taken (rd_taken),
    .rd_target(rd_target),
    .wr_req   (wr_req),
    .wr_pc    (wr_pc),
    .wr_target(wr_target),
    .wr_taken (wr_taken),
    .flush    (flush),
    .busy     (busy)
`ifdef BTB_STATS_EN
    ,
    .hit_cnt       (hit_cnt),
    .mispredict_cnt(mispredict_cnt)
`endif
  );

  typedef struct {
    string       name;
    logic        hit;
    logic        taken;
    logic [31:0] target;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];
  logic chk_valid = 1'b0;
  int   errors = 0;
  int   checks = 0;

  // Monitor: compares the oldest expectation whenever a lookup is presented
  always @(negedge clk) begin
    exp_t e;
    if (chk_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: lookup presented with no expectation queued");
      end else begin
        e = exp_q.pop_front();
        if ({rd_hit, rd_taken, rd_target, busy} !== {e.hit, e.taken, e.target, e.busy}) begin
          errors++;
          $display("FAIL %s: got hit=%0b taken=%0b target=%h busy=%0b, required hit=%0b taken=%0b target=%h busy=%0b",
                   e.name, rd_hit, rd_taken, rd_target, busy, e.hit, e.taken, e.target, e.busy);
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    chk_valid = 1'b0;
    wr_req    = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic expect_rd(input string name, input logic [31:0] pc, input logic hit,
                           input logic taken, input logic [31:0] tgt, input logic bsy);
    rd_pc     = pc;
    chk_valid = 1'b1;
    exp_q.push_back('{name, hit, taken, tgt, bsy});
  endtask

  task automatic set_wr(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    wr_req    = 1'b1;
    wr_pc     = pc;
    wr_target = tgt;
    wr_taken  = tk;
  endtask

  task automatic wr(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    set_wr(pc, tgt, tk);
    cycle();
  endtask

  task automatic lookup(input string name, input logic [31:0] pc, input logic hit,
                        input logic taken, input logic [31:0] tgt);
    expect_rd(name, pc, hit, taken, tgt, 1'b0);
    cycle();
  endtask

`ifdef BTB_STATS_EN
  task automatic chk_cnt(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask
`endif

  initial begin
    rst       = 1'b1;
    rd_pc     = '0;
    wr_req    = 1'b0;
    wr_pc     = '0;
    wr_target = '0;
    wr_taken  = 1'b0;
    flush     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    lookup("reset_miss", 32'h100, 1'b0, 1'b0, 32'h0);

    // Allocate, then weaken the counter with two not-taken updates
    wr(32'h100, 32'h200, 1'b1);
    lookup("alloc_hit", 32'h100, 1'b1, 1'b1, 32'h200);
    wr(32'h100, 32'h999, 1'b0);
    lookup("not_taken_1", 32'h100, 1'b1, 1'b0, 32'h200);
    wr(32'h100, 32'h999, 1'b0);
    lookup("not_taken_2", 32'h100, 1'b1, 1'b0, 32'h200);
`ifdef BTB_STATS_EN
    chk_cnt("hit_cnt_seq", hit_cnt, 32'd2);
    chk_cnt("mispredict_cnt_seq", mispredict_cnt, 32'd2);
`endif

    // A lookup in the update cycle sees the old contents
    set_wr(32'h140, 32'h440, 1'b1);
    expect_rd("same_cycle_pre", 32'h140, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle();
    lookup("post_update", 32'h140, 1'b1, 1'b1, 32'h440);

    // Three tags into set 0 of a 2-way table: 0x100 is the round-robin victim
    wr(32'h200, 32'h1000, 1'b1);
    wr(32'h300, 32'h2000, 1'b1);
    lookup("evicted_100", 32'h100, 1'b0, 1'b0, 32'h0);
    lookup("kept_200", 32'h200, 1'b1, 1'b1, 32'h1000);
    lookup("kept_300", 32'h300, 1'b1, 1'b1, 32'h2000);
    wr(32'h400, 32'h3000, 1'b0);
    lookup("nt_miss_no_alloc", 32'h400, 1'b0, 1'b0, 32'h0);
    lookup("nt_miss_keeps_300", 32'h300, 1'b1, 1'b1, 32'h2000);
    wr(32'h200, 32'h1500, 1'b1);
    lookup("retarget_200", 32'h200, 1'b1, 1'b1, 32'h1500);
`ifdef BTB_STATS_EN
    chk_cnt("hit_cnt_mid", hit_cnt, 32'd3);
    chk_cnt("mispredict_cnt_mid", mispredict_cnt, 32'd6);
`endif

    // Flush sweep: busy for exactly 64 cycles, lookups gated, updates ignored
    flush = 1'b1;
    cycle();
    for (int i = 0; i < 64; i++) begin
      if (i == 5) set_wr(32'h500, 32'h5000, 1'b1);
      if (i == 7) flush = 1'b1;
      expect_rd("sweep_busy", 32'h140, 1'b0, 1'b0, 32'h0, 1'b1);
      cycle();
    end
    lookup("sweep_done_140", 32'h140, 1'b0, 1'b0, 32'h0);
    lookup("sweep_done_200", 32'h200, 1'b0, 1'b0, 32'h0);
    lookup("sweep_done_300", 32'h300, 1'b0, 1'b0, 32'h0);
    lookup("sweep_write_dropped", 32'h500, 1'b0, 1'b0, 32'h0);

    // Flush and update together: update dropped
    set_wr(32'h600, 32'h6000, 1'b1);
    flush = 1'b1;
    cycle();
    repeat (64) cycle();
    lookup("flush_wins_600", 32'h600, 1'b0, 1'b0, 32'h0);
`ifdef BTB_STATS_EN
    chk_cnt("hit_cnt_after_flush", hit_cnt, 32'd3);
    chk_cnt("mispredict_cnt_after_flush", mispredict_cnt, 32'd6);
`endif

    // Reset part-way through a sweep
    wr(32'h100, 32'h200, 1'b1);
    lookup("realloc_100", 32'h100, 1'b1, 1'b1, 32'h200);
    flush = 1'b1;
    cycle();
    repeat (9) cycle();
    expect_rd("sweep_cycle_9", 32'h100, 1'b0, 1'b0, 32'h0, 1'b1);
    cycle();
    rst = 1'b1;
    expect_rd("rst_mid_sweep", 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle();
    rst = 1'b0;
    lookup("after_rst_miss", 32'h100, 1'b0, 1'b0, 32'h0);
    wr(32'h1fc, 32'hbeef, 1'b1);
    lookup("after_rst_alloc", 32'h1fc, 1'b1, 1'b1, 32'hbeef);
`ifdef BTB_STATS_EN
    chk_cnt("hit_cnt_after_rst", hit_cnt, 32'd0);
    chk_cnt("mispredict_cnt_after_rst", mispredict_cnt, 32'd1);
`endif

    repeat (2) cycle();
    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btb_assoc.md
BTB_ASSOC -- requirements
Module: btb_assoc

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 6, meaning set-index width; sets = 2**INDEX_BITS.
REQ-002 SHALL have parameter WAYS, default 2, meaning associativity; legal values 1, 2, 4.
REQ-003 SHALL have parameter CTR_BITS, default 2, meaning width of the per-entry saturating direction counter; legal range 1-4.
REQ-004 SHALL have port clk input 1, the clock.
REQ-005 SHALL have port rst input 1, the reset: asynchronous, active-high.
REQ-006 SHALL have port rd_pc input 32, the lookup PC.
REQ-007 SHALL have port rd_hit output 1, meaning rd_pc matches a valid entry.
REQ-008 SHALL have port rd_taken output 1, meaning predict taken.
REQ-009 SHALL have port rd_target output 32, the predicted target.
REQ-010 SHALL have port wr_req input 1, a resolved-branch update strobe.
REQ-011 SHALL have port wr_pc input 32, the resolved branch PC.
REQ-012 SHALL have port wr_target input 32, the resolved target.
REQ-013 SHALL have port wr_taken input 1, the resolved direction.
REQ-014 SHALL have port flush input 1, a single-cycle request to invalidate all entries.
REQ-015 SHALL have port busy output 1, high while a flush sweep is in progress.

Function
REQ-016 SHALL split the PC as tag = pc[31:INDEX_BITS+2], index = pc[INDEX_BITS+1:2], with pc[1:0] ignored.
REQ-017 SHALL hold per entry: valid, tag, target[31:0], ctr[CTR_BITS-1:0]; per set: rr_ptr (round-robin pointer, log2(WAYS) bits, absent when WAYS=1).
REQ-018 SHALL make lookup combinational, with zero-cycle latency: rd_hit = some way with valid and tag equal; rd_target = that way's target; rd_taken = rd_hit & ctr MSB.
REQ-019 SHALL drive rd_hit, rd_taken and rd_target to 0 when there is no hit or busy=1.
REQ-020 SHALL update state on the clk edge when wr_req=1 and busy=0; lookup in the same cycle sees pre-update contents.
REQ-021 SHALL handle an update hit as follows: ctr increments if wr_taken and decrements if not, saturating at all-ones/0; target is overwritten only if wr_taken.
REQ-022 SHALL handle an update miss with wr_taken=1 by allocating: victim = lowest-index invalid way, else way rr_ptr; write valid=1, tag, target, ctr=weakly-taken (MSB=1, rest 0); rr_ptr advances by 1 modulo WAYS only when the victim was chosen by rr_ptr.
REQ-023 SHALL make an update miss with wr_taken=0 leave all state unchanged.
REQ-024 SHALL use an FSM with states IDLE and SWEEP: flush=1 in IDLE moves to SWEEP with sweep index 0; each SWEEP cycle clears valid in all ways and rr_ptr of the current set; after set 2**INDEX_BITS-1 the FSM returns to IDLE.
REQ-025 SHALL assert busy exactly in SWEEP, for 2**INDEX_BITS cycles starting the cycle after flush is sampled.
REQ-026 SHALL ignore flush during SWEEP.
REQ-027 SHALL resolve flush and wr_req in the same IDLE cycle in favour of flush: the update is dropped.

Reset
REQ-028 SHALL, on rst=1 asynchronously, clear all valid bits, all rr_ptr values and all ctr values, set the FSM to IDLE and clear the sweep index; tag and target storage are not reset.
REQ-029 SHALL, after reset, output rd_hit=0, rd_taken=0, rd_target=0 and busy=0.
REQ-030 SHALL, on rst asserted mid-sweep, abort the sweep and leave busy=0 immediately.

Configuration
REQ-031 SHALL add output ports hit_cnt[31:0] and mispredict_cnt[31:0] when macro BTB_STATS_EN is defined; without the macro these ports and counters do not exist.
REQ-032 SHALL, with BTB_STATS_EN, increment hit_cnt on each accepted wr_req that hits, and increment mispredict_cnt on each accepted wr_req where the pre-update prediction (hit & ctr MSB, and target equal if taken) differs from the outcome; both counters wrap at 2**32, reset to 0, and are not cleared by flush.

Verification
REQ-033 SHALL cover: after reset, rd_pc=0x100 -> rd_hit=0, rd_taken=0, rd_target=0.
REQ-034 SHALL cover: wr_req with pc 0x100, target 0x200, taken=1, then rd_pc=0x100 -> rd_hit=1, rd_taken=1, rd_target=0x200; two further not-taken updates -> rd_hit=1, rd_taken=0.
REQ-035 SHALL cover, with INDEX_BITS=6 and WAYS=2: taken updates to 0x100, 0x200 and 0x300 (same index 0) -> 0x100 evicted, 0x200 and 0x300 hit.
REQ-036 SHALL cover: flush pulse -> busy high for exactly 64 cycles, rd_hit=0 throughout; a wr_req during the sweep is ignored; all entries miss afterwards.
REQ-037 SHALL cover: flush and wr_req in the same cycle -> the update is dropped; rst asserted at sweep cycle 10 -> busy=0 at once.
REQ-038 SHALL cover, with BTB_STATS_EN: the REQ-034 sequence -> hit_cnt=2, mispredict_cnt=2 (the first update misses; the second is not taken against a taken prediction).
